ascii_to_ps2_tx: RTL
====================

Name: ascii_to_ps2_tx

Overview:
- Keyboard-side PS/2 transmitter and the inverse of the keycode-to-ASCII decode path.
- Accepts one ASCII command character and looks it up in the team's key table to get a Set-2 scan code.
- Serialises the full make/break sequence onto PS/2 clock/data lines.
- Used as an on-board keyboard emulator and as the stimulus source for the PS/2 receiver and decoder chain.

Parameters:
- QUARTER, default 2000: system-clock cycles per quarter PS/2 bit cell. 100 MHz gives an 80 us cell, 12.5 kHz.
- BYTE_GAP, default 100000: idle cycles between bytes of one sequence. Both lines are high during the gap.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ascii_in  input  8  character to send; sampled when send_strobe is accepted
- send_strobe  input  1  one-cycle request
- ready  output  1  high in IDLE; a strobe is accepted only when ready=1
- done_tick  output  1  one-cycle pulse after the last bit cell of the sequence
- unmapped_tick  output  1  one-cycle pulse when an accepted character has no table entry
- ps2c  output  1  PS/2 clock, idle 1
- ps2d  output  1  PS/2 data, idle 1

Behaviour:
- Reset values: ready=1, done_tick=0, unmapped_tick=0, ps2c=1, ps2d=1, state IDLE, all counters 0.
- Reset is honoured mid-frame: lines return to 1 immediately and no done_tick is produced.
- Table (ASCII -> code, E = extended):
  - 21->05, 22->06, 41->1C, 44->23, 46->2B, 48->33, 4D->3A, 52->2D, 53->1B, 54->2C, 0D->5A
  - 35->72E, 34->6BE, 36->74E, 38->75E
- Byte sequences:
  - Normal: code, F0, code (3 bytes).
  - Extended: E0, code, E0, F0, code (5 bytes).
  - Sequence is held in a byte buffer of up to 5 entries, with a length register and an index counter.
- States: IDLE -> LOAD -> FRAME -> GAP -> FRAME ... -> DONE -> IDLE.
- IDLE:
  - send_strobe=1 with ready=1 captures ascii_in; ready drops on the next edge.
  - If unmapped: unmapped_tick pulses one cycle after the strobe, state returns to IDLE, lines never move, ready=1 again in that cycle.
  - If mapped: go to LOAD (one cycle, fills the buffer).
- FRAME:
  - 11 bit cells: start 0, 8 data bits LSB first, odd parity, stop 1.
  - Each cell is 4 quarters:
    - Q0: ps2d updates; ps2c=1.
    - Q1: ps2c=1.
    - Q2 and Q3: ps2c=0.
  - The falling ps2c edge is at the start of Q2, so data is stable 2*QUARTER before it.
  - The cell counter counts QUARTER-1 down to 0 per quarter; the bit counter runs 0..10.
  - Frame length is 44*QUARTER cycles.
  - The first cell's Q0 starts the cycle after LOAD.
- GAP: after each non-final frame, both lines are 1 for BYTE_GAP cycles, then the next frame starts.
- DONE: after the final stop cell ends, done_tick is high for one cycle and the block returns to IDLE with ready=1.
- Parity: the parity bit makes the total number of 1s across data plus parity odd. It is computed from the buffer byte, not on the fly.
- A send_strobe while ready=0 is ignored and not queued.
- A strobe in the same cycle as the done_tick cycle is ignored. It is accepted from the following cycle.

Optional Feature:
PS2_HOST_INHIBIT_EN
- Enabled:
  - Adds input ps2c_in (sensed PS/2 clock line, synchronised with 2 flops inside the block).
  - In IDLE/LOAD/GAP, ps2c_in=0 defers the start of the next frame until the line is released and has stayed high for BYTE_GAP cycles.
  - In FRAME, ps2c_in=0 sampled in Q1 of bits 0..9 aborts the frame: lines go to 1, the block waits for release plus BYTE_GAP, then resends the same byte from the start bit.
  - Inhibit during bit 10 is ignored and the byte completes.
- Disabled: port absent; frames are never deferred or aborted.

Test Plan (QUARTER=4, BYTE_GAP=20):
- reset, strobe 0x41 ->
  - frames 1C, F0, 1C.
  - 1C data bits 0,0,1,1,1,0,0,0, parity 0.
  - F0 parity 1.
  - 2 gaps of 20 cycles.
  - done_tick after 3*176+40 cycles plus LOAD.
- strobe 0x38 ->
  - frames E0, 75, E0, F0, 75.
  - E0 parity 0; 75 parity 0.
  - 4 gaps.
  - single done_tick.
- strobe 0x61 -> unmapped_tick one cycle later; ps2c/ps2d never leave 1; ready back to 1; no done_tick.
- strobe 0x0D, then strobe 0x41 during frame 2 -> second strobe ignored; only 5A, F0, 5A sent; ready=0 throughout.
- reset asserted during bit 5 of the first frame of 0x53 -> ps2c=ps2d=1 asynchronously; ready=1; no done_tick; a fresh 0x53 sends 1B, F0, 1B correctly.
- PS2_HOST_INHIBIT_EN: ps2c_in held 0 for 30 cycles during bit 3 of 0x46 -> frame aborts; after release+20 cycles, 2B is resent in full; the sequence completes with one done_tick.

Source files
------------

// File: rtl/ascii_to_ps2_tx.sv
// ASCII command character -> PS/2 Set-2 make/break sequence, serialised as keyboard-side frames.
// Optional PS2_HOST_INHIBIT_EN adds ps2c_in so the host can defer frames or abort them mid-frame.
module ascii_to_ps2_tx #(
  parameter int unsigned QUARTER  = 2000,
  parameter int unsigned BYTE_GAP = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       send_strobe,
`ifdef PS2_HOST_INHIBIT_EN
  input  logic       ps2c_in,
`endif
  output logic       ready,
  output logic       done_tick,
  output logic       unmapped_tick,
  output logic       ps2c,
  output logic       ps2d
);

  localparam int unsigned TMAX = (QUARTER > BYTE_GAP) ? QUARTER : BYTE_GAP;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      code_q, code_d;
  logic            ext_q, ext_d;
  logic [4:0][7:0] buf_q, buf_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [3:0]      bit_q, bit_d;
  logic            unmapped_q, unmapped_d;

  logic            lk_hit, lk_ext;
  logic [7:0]      lk_code;
  logic [7:0]      cur_byte;
  logic [3:0]      data_sel;
  logic            cell_bit;
  logic            host_clr, host_inh;

`ifdef PS2_HOST_INHIBIT_EN
  logic          sync1_q, sync2_q;
  logic [TW-1:0] hold_q, hold_d;

  // hold counts down BYTE_GAP cycles of released line before frames may start again
  always_comb begin
    hold_d = hold_q;
    if (!sync2_q)          hold_d = TW'(BYTE_GAP);
    else if (hold_q != '0) hold_d = hold_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hold_q  <= '0;
    end else begin
      sync1_q <= ps2c_in;
      sync2_q <= sync1_q;
      hold_q  <= hold_d;
    end
  end

  assign host_clr = sync2_q && (hold_q == '0);
  assign host_inh = !sync2_q;
`else
  assign host_clr = 1'b1;
  assign host_inh = 1'b0;
`endif

  always_comb begin
    lk_hit  = 1'b1;
    lk_ext  = 1'b0;
    lk_code = '0;
    case (ascii_in)
      8'h21: lk_code = 8'h05;
      8'h22: lk_code = 8'h06;
      8'h41: lk_code = 8'h1C;
      8'h44: lk_code = 8'h23;
      8'h46: lk_code = 8'h2B;
      8'h48: lk_code = 8'h33;
      8'h4D: lk_code = 8'h3A;
      8'h52: lk_code = 8'h2D;
      8'h53: lk_code = 8'h1B;
      8'h54: lk_code = 8'h2C;
      8'h0D: lk_code = 8'h5A;
      8'h35: begin lk_code = 8'h72; lk_ext = 1'b1; end
      8'h34: begin lk_code = 8'h6B; lk_ext = 1'b1; end
      8'h36: begin lk_code = 8'h74; lk_ext = 1'b1; end
      8'h38: begin lk_code = 8'h75; lk_ext = 1'b1; end
      default: lk_hit = 1'b0;
    endcase
  end

  assign cur_byte = buf_q[idx_q];
  assign data_sel = bit_q - 4'd1;

  always_comb begin
    case (bit_q)
      4'd0:    cell_bit = 1'b0;
      4'd9:    cell_bit = ~^cur_byte;
      4'd10:   cell_bit = 1'b1;
      default: cell_bit = cur_byte[data_sel[2:0]];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    ext_d      = ext_q;
    buf_d      = buf_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    unmapped_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (send_strobe) begin
          if (lk_hit) begin
            code_d  = lk_code;
            ext_d   = lk_ext;
            state_d = S_LOAD;
          end else begin
            unmapped_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ext_q) begin
          buf_d = {code_q, 8'hF0, 8'hE0, code_q, 8'hE0};
          len_d = 3'd5;
        end else begin
          buf_d = {8'h00, 8'h00, code_q, 8'hF0, code_q};
          len_d = 3'd3;
        end
        idx_d = '0;
        bit_d = '0;
        qtr_d = '0;
        if (host_clr) begin
          state_d = S_FRAME;
          tmr_d   = TW'(QUARTER - 1);
        end else begin
          state_d = S_GAP;
          tmr_d   = '0;
        end
      end
      S_FRAME: begin
        // abort restarts the same byte (idx unchanged) once the host releases the clock
        if (host_inh && qtr_q == 2'd1 && bit_q <= 4'd9) begin
          state_d = S_GAP;
          tmr_d   = '0;
          bit_d   = '0;
          qtr_d   = '0;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          tmr_d = TW'(QUARTER - 1);
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 4'd10) begin
              bit_d = '0;
              if (idx_q == len_q - 3'd1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_GAP;
                idx_d   = idx_q + 3'd1;
                tmr_d   = TW'(BYTE_GAP - 1);
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (host_clr) begin
          state_d = S_FRAME;
          tmr_d   = TW'(QUARTER - 1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      ext_q      <= 1'b0;
      buf_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      unmapped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign ready         = (state_q == S_IDLE);
  assign done_tick     = (state_q == S_DONE);
  assign unmapped_tick = unmapped_q;
  assign ps2c          = !((state_q == S_FRAME) && qtr_q[1]);
  assign ps2d          = (state_q == S_FRAME) ? cell_bit : 1'b1;

endmodule
